mc_control_unit: RTL and testbench

Multi-cycle control unit for the single-issue MIPS-subset core: a Moore/Mealy FSM that sequences each instruction through IF/ID/EXE/MEM/WB and produces every datapath control strobe. It sits directly upstream of the program counter register and drives its write enable (`PCWre`) and next-address select (`PCSrc`). It also drives the IR, register-file, ALU and data-memory controls.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/mc_control_unit_if.sv | 37 +++
 rtl/ctrl_decode.sv | 109 ++++++++++
 rtl/mc_control_unit.sv | 66 ++++++
 tb/tb_mc_control_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// == ctrl_pkg : opcode, state and control-code encodings for mc_control_unit ==
// == rev 1.0                                                                    ==
`default_nettype none

package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] DST_RA = 2'b00;
   localparam logic [1:0] DST_RT = 2'b01;
   localparam logic [1:0] DST_RD = 2'b10;

   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_SLT) || (op == OP_SLL);
   endfunction

   function automatic logic is_alu_op(input logic [5:0] op);
      return is_rtype(op) || (op == OP_ADDIU) || (op == OP_ANDI) ||
             (op == OP_ORI) || (op == OP_SLTI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_unit_if.sv
// == mc_control_unit_if : status inputs and control strobes between FSM and datapath ==
// == rev 1.0                                                                           ==
`default_nettype none

interface mc_control_unit_if;
   logic [5:0] opcode;
   logic       zero;
   logic       sign;
   logic       PCWre;
   logic [1:0] PCSrc;
   logic       IRWre;
   logic       RegWre;
   logic [1:0] RegDst;
   logic       WrRegDSrc;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic [2:0] ALUOp;
   logic       ExtSel;
   logic       mRD;
   logic       mWR;
   logic       DBDataSrc;
   logic [2:0] state;

   modport master (
      input  opcode, zero, sign,
      output PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
             ALUOp, ExtSel, mRD, mWR, DBDataSrc, state
   );

   modport slave (
      output opcode, zero, sign,
      input  PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
             ALUOp, ExtSel, mRD, mWR, DBDataSrc, state
   );
endinterface

`default_nettype wire

// File: rtl/ctrl_decode.sv
// == ctrl_decode : combinational (state, opcode, zero, sign) -> control strobes ==
// == rev 1.0                                                                     ==
`default_nettype none

module ctrl_decode
   import ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc
);

   always_comb begin
      PCWre     = 1'b0;
      PCSrc     = PC_SEQ;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      RegDst    = DST_RA;
      WrRegDSrc = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      ExtSel    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;

      // The opcode is stale during fetch, so datapath selects only follow it afterwards.
      if (state != S_IF) begin
         case (opcode)
            OP_SUB:   ALUOp = ALU_SUB;
            OP_ADDIU: begin ALUOp = ALU_ADD; ExtSel = 1'b1; ALUSrcB = 1'b1; end
            OP_AND:   ALUOp = ALU_AND;
            OP_ANDI:  begin ALUOp = ALU_AND; ALUSrcB = 1'b1; end
            OP_ORI:   begin ALUOp = ALU_OR;  ALUSrcB = 1'b1; end
            OP_SLL:   begin ALUOp = ALU_SLL; ALUSrcA = 1'b1; end
            OP_SLT:   ALUOp = ALU_SLT;
            OP_SLTI:  begin ALUOp = ALU_SLT; ExtSel = 1'b1; ALUSrcB = 1'b1; end
            OP_SW, OP_LW: begin ALUOp = ALU_ADD; ExtSel = 1'b1; ALUSrcB = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin ALUOp = ALU_SUB; ExtSel = 1'b1; end
            default: ;
         endcase
      end

      case (state)
         S_IF: IRWre = 1'b1;
         S_ID: begin
            case (opcode)
               OP_J:  begin PCWre = 1'b1; PCSrc = PC_JUMP; end
               OP_JR: begin PCWre = 1'b1; PCSrc = PC_RS; end
               OP_JAL: begin
                  PCWre  = 1'b1;
                  PCSrc  = PC_JUMP;
                  RegWre = 1'b1;
                  RegDst = DST_RA;
               end
               default: ;
            endcase
         end
         S_EXE_BR: begin
            // PCWre stays unconditional so only PCSrc depends on the ALU flags.
            PCWre = 1'b1;
            if ((opcode == OP_BEQ  &&  zero) ||
                (opcode == OP_BNE  && !zero) ||
                (opcode == OP_BLTZ &&  sign))
               PCSrc = PC_BRANCH;
         end
         S_MEM: begin
            if (opcode == OP_SW) begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end else if (opcode == OP_LW) begin
               mRD = 1'b1;
            end
         end
         S_WB_LD: begin
            RegWre    = 1'b1;
            RegDst    = DST_RT;
            WrRegDSrc = 1'b1;
            DBDataSrc = 1'b1;
            PCWre     = 1'b1;
         end
         S_WB_AL: begin
            RegWre    = 1'b1;
            RegDst    = is_rtype(opcode) ? DST_RD : DST_RT;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// == mc_control_unit : multi-cycle FSM sequencing IF/ID/EXE/MEM/WB for the MIPS-subset core ==
// == rev 1.0                                                                                  ==
`default_nettype none

module mc_control_unit
   import ctrl_pkg::*;
(
   input  logic                CLK,
   input  logic                Reset,
   mc_control_unit_if.master   bus
);

   state_t cur_state;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cur_state <= S_IF;
      end else begin
         case (cur_state)
            S_IF: cur_state <= S_ID;
            S_ID: begin
               case (bus.opcode)
                  OP_J, OP_JR, OP_JAL:     cur_state <= S_IF;
                  OP_HALT:                 cur_state <= S_ID;
                  OP_BEQ, OP_BNE, OP_BLTZ: cur_state <= S_EXE_BR;
                  OP_SW, OP_LW:            cur_state <= S_EXE_LS;
                  // Unknown opcodes fall back to fetch and retire as a nop.
                  default: cur_state <= is_alu_op(bus.opcode) ? S_EXE_AL : S_IF;
               endcase
            end
            S_EXE_AL: cur_state <= S_WB_AL;
            S_WB_AL:  cur_state <= S_IF;
            S_EXE_BR: cur_state <= S_IF;
            S_EXE_LS: cur_state <= S_MEM;
            S_MEM:    cur_state <= (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  cur_state <= S_IF;
            default:  cur_state <= S_IF;
         endcase
      end
   end

   assign bus.state = cur_state;

   ctrl_decode u_decode (
      .state     (cur_state),
      .opcode    (bus.opcode),
      .zero      (bus.zero),
      .sign      (bus.sign),
      .PCWre     (bus.PCWre),
      .PCSrc     (bus.PCSrc),
      .IRWre     (bus.IRWre),
      .RegWre    (bus.RegWre),
      .RegDst    (bus.RegDst),
      .WrRegDSrc (bus.WrRegDSrc),
      .ALUSrcA   (bus.ALUSrcA),
      .ALUSrcB   (bus.ALUSrcB),
      .ALUOp     (bus.ALUOp),
      .ExtSel    (bus.ExtSel),
      .mRD       (bus.mRD),
      .mWR       (bus.mWR),
      .DBDataSrc (bus.DBDataSrc)
   );

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// == tb_mc_control_unit : directed per-cycle checks of the multi-cycle control unit ==
// == rev 1.0                                                                         ==
`default_nettype none

module tb_mc_control_unit;

   typedef struct packed {
      logic [2:0] st;
      logic       pcwre;
      logic [1:0] pcsrc;
      logic       irwre;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       srca;
      logic       srcb;
      logic [2:0] aluop;
      logic       ext;
      logic       mrd;
      logic       mwr;
      logic       dbsrc;
   } rec_t;

   logic clk;
   logic Reset;
   int   checks;
   int   failures;
   rec_t exp_q[$];
   string tag_q[$];

   mc_control_unit_if u_if ();

   mc_control_unit dut (
      .CLK   (clk),
      .Reset (Reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic rec_t mk(input logic [2:0] st, input logic [2:0] aluop,
                               input logic ext, input logic srca, input logic srcb);
      rec_t r;
      r       = '0;
      r.st    = st;
      r.irwre = (st == 3'b000);
      r.aluop = aluop;
      r.ext   = ext;
      r.srca  = srca;
      r.srcb  = srcb;
      return r;
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.st     = u_if.state;
      r.pcwre  = u_if.PCWre;
      r.pcsrc  = u_if.PCSrc;
      r.irwre  = u_if.IRWre;
      r.regwre = u_if.RegWre;
      r.regdst = u_if.RegDst;
      r.wrsrc  = u_if.WrRegDSrc;
      r.srca   = u_if.ALUSrcA;
      r.srcb   = u_if.ALUSrcB;
      r.aluop  = u_if.ALUOp;
      r.ext    = u_if.ExtSel;
      r.mrd    = u_if.mRD;
      r.mwr    = u_if.mWR;
      r.dbsrc  = u_if.DBDataSrc;
      return r;
   endfunction

   task automatic push(input rec_t e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   // One expected record is consumed per clock, sampled on the falling edge.
   task automatic drain();
      rec_t  e;
      rec_t  obs;
      string t;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         obs = sample();
         checks++;
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic set_in(input logic [5:0] op, input logic z, input logic s);
      u_if.opcode = op;
      u_if.zero   = z;
      u_if.sign   = s;
   endtask

   initial begin
      rec_t e;
      rec_t s_if;
      checks   = 0;
      failures = 0;
      s_if     = mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      Reset    = 1'b1;
      set_in(6'b000000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      push(s_if, "reset_if");
      drain();
      Reset = 1'b0;

      // sw interrupted by a two-cycle reset during its memory state
      set_in(6'b110000, 1'b0, 1'b0);
      e = mk(3'b001, 3'b000, 1'b1, 1'b0, 1'b1); push(e, "sw_id");
      e.st = 3'b010;                            push(e, "sw_exe");
      e.st = 3'b011; e.mwr = 1'b1; e.pcwre = 1'b1; push(e, "sw_mem");
      drain();
      Reset = 1'b1;
      push(s_if, "rst_mid_mem_1");
      push(s_if, "rst_mid_mem_2");
      drain();
      Reset = 1'b0;

      // add
      set_in(6'b000000, 1'b0, 1'b0);
      e = mk(3'b001, 3'b000, 1'b0, 1'b0, 1'b0); push(e, "add_id");
      e.st = 3'b110;                            push(e, "add_exe");
      e.st = 3'b111; e.regwre = 1'b1; e.regdst = 2'b10; e.pcwre = 1'b1; e.wrsrc = 1'b1;
      push(e, "add_wb");
      push(s_if, "add_next_if");
      drain();

      // ori: zero-extended immediate, rt destination
      set_in(6'b010010, 1'b0, 1'b0);
      e = mk(3'b001, 3'b011, 1'b0, 1'b0, 1'b1); push(e, "ori_id");
      e.st = 3'b110;                            push(e, "ori_exe");
      e.st = 3'b111; e.regwre = 1'b1; e.regdst = 2'b01; e.pcwre = 1'b1; e.wrsrc = 1'b1;
      push(e, "ori_wb");
      push(s_if, "ori_next_if");
      drain();

      // lw
      set_in(6'b110001, 1'b0, 1'b0);
      e = mk(3'b001, 3'b000, 1'b1, 1'b0, 1'b1); push(e, "lw_id");
      e.st = 3'b010;                            push(e, "lw_exe");
      e.st = 3'b011; e.mrd = 1'b1;              push(e, "lw_mem");
      e.st = 3'b100; e.mrd = 1'b0; e.regwre = 1'b1; e.regdst = 2'b01;
      e.dbsrc = 1'b1; e.wrsrc = 1'b1; e.pcwre = 1'b1;
      push(e, "lw_wb");
      push(s_if, "lw_next_if");
      drain();

      // beq taken / not taken, bne taken, bltz taken
      set_in(6'b110100, 1'b1, 1'b0);
      e = mk(3'b001, 3'b001, 1'b1, 1'b0, 1'b0); push(e, "beq_t_id");
      e.st = 3'b101; e.pcwre = 1'b1; e.pcsrc = 2'b01; push(e, "beq_taken");
      push(s_if, "beq_t_next_if");
      drain();

      set_in(6'b110100, 1'b0, 1'b0);
      e = mk(3'b001, 3'b001, 1'b1, 1'b0, 1'b0); push(e, "beq_n_id");
      e.st = 3'b101; e.pcwre = 1'b1; e.pcsrc = 2'b00; push(e, "beq_not_taken");
      push(s_if, "beq_n_next_if");
      drain();

      set_in(6'b110101, 1'b0, 1'b0);
      e = mk(3'b001, 3'b001, 1'b1, 1'b0, 1'b0); push(e, "bne_id");
      e.st = 3'b101; e.pcwre = 1'b1; e.pcsrc = 2'b01; push(e, "bne_taken");
      push(s_if, "bne_next_if");
      drain();

      set_in(6'b110110, 1'b0, 1'b1);
      e = mk(3'b001, 3'b001, 1'b1, 1'b0, 1'b0); push(e, "bltz_id");
      e.st = 3'b101; e.pcwre = 1'b1; e.pcsrc = 2'b01; push(e, "bltz_taken");
      push(s_if, "bltz_next_if");
      drain();

      // jal and jr
      set_in(6'b111010, 1'b0, 1'b0);
      e = mk(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
      e.pcwre = 1'b1; e.pcsrc = 2'b11; e.regwre = 1'b1; e.regdst = 2'b00; e.wrsrc = 1'b0;
      push(e, "jal_id");
      push(s_if, "jal_next_if");
      drain();

      set_in(6'b111001, 1'b0, 1'b0);
      e = mk(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
      e.pcwre = 1'b1; e.pcsrc = 2'b10;
      push(e, "jr_id");
      push(s_if, "jr_next_if");
      drain();

      // halt holds in decode until reset
      set_in(6'b111111, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         push(mk(3'b001, 3'b000, 1'b0, 1'b0, 1'b0), $sformatf("halt_hold_%0d", i));
      drain();
      Reset = 1'b1;
      push(s_if, "halt_reset_if");
      drain();
      Reset = 1'b0;

      // undefined opcode retires as a nop
      set_in(6'b101010, 1'b0, 1'b0);
      push(mk(3'b001, 3'b000, 1'b0, 1'b0, 1'b0), "undef_id");
      push(s_if, "undef_next_if");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
